// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - state encoding and program-memory geometry for the TD4 run controller
package td4_pkg;

  localparam int TD4_IMEM_DEPTH = 16;
  localparam int TD4_ADDR_W     = 4;
  localparam int TD4_INSTR_W    = 8;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_HALT = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } td4_state_e;

endpackage

// File: rtl/td4_run_ctrl_if.sv
// rtl/td4_run_ctrl_if.sv - program-load stream in, program-memory write port out
interface td4_run_ctrl_if;
  import td4_pkg::*;

  logic                   load_valid;
  logic                   load_ready;
  logic [TD4_ADDR_W-1:0]  load_addr;
  logic [TD4_INSTR_W-1:0] load_data;
  logic                   load_last;
  logic                   prog_we;
  logic [TD4_ADDR_W-1:0]  prog_addr;
  logic [TD4_INSTR_W-1:0] prog_wdata;

  modport master (
    output load_valid, load_addr, load_data, load_last,
    input  load_ready, prog_we, prog_addr, prog_wdata
  );

  modport slave (
    input  load_valid, load_addr, load_data, load_last,
    output load_ready, prog_we, prog_addr, prog_wdata
  );

endinterface

// File: rtl/td4_rate_div.sv
// rtl/td4_rate_div.sv - RUN-mode divider; tick marks the last cycle of each STEP_DIV period
module td4_rate_div #(
  parameter int STEP_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(STEP_DIV - 1);

  logic [15:0] div_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 16'd1;
    end
  end

  assign tick = enable & (div_cnt == LAST);

endmodule

// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 load/reset/run/step/halt sequencer
// TD4_BREAKPOINT_EN adds a single-address breakpoint that halts free-run before the matching ip executes.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int STEP_DIV   = 1,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  restart_req,
  td4_run_ctrl_if.slave         load_bus,
`ifdef TD4_BREAKPOINT_EN
  input  logic [TD4_ADDR_W-1:0] cpu_ip,
  input  logic [TD4_ADDR_W-1:0] bp_addr,
  input  logic                  bp_enable,
  output logic                  bp_hit,
`endif
  output logic                  cpu_en,
  output logic                  cpu_rst_n,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYCLES - 1);

  td4_state_e       state_q;
  td4_state_e       state_d;
  logic [CLR_W-1:0] clr_cnt;
  logic             tick;
  logic             accept;
  logic             cpu_en_d;

  assign accept = load_bus.load_valid & load_bus.load_ready;
  assign state  = state_q;

  td4_rate_div #(
    .STEP_DIV(STEP_DIV)
  ) u_rate_div (
    .clock (clock),
    .reset (reset),
    .clear (state_q != ST_RUN),
    .enable(state_q == ST_RUN),
    .tick  (tick)
  );

`ifdef TD4_BREAKPOINT_EN
  logic first_q;
  logic bp_stop;
  logic bp_match;

  // The first pulse after RUN entry is never checked so a resumed run steps past the breakpoint.
  assign bp_match = bp_enable & (cpu_ip == bp_addr) & ~first_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
`ifdef TD4_BREAKPOINT_EN
    bp_stop  = 1'b0;
`endif
    case (state_q)
      ST_CLR: begin
        if (clr_cnt == CLR_LAST) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (load_bus.load_valid) begin
          state_d = ST_LOAD;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (restart_req) begin
          state_d = ST_CLR;
        end else if (step_req) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end else if (run_req) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (accept && load_bus.load_last) state_d = ST_CLR;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (restart_req) begin
          state_d = ST_CLR;
        end else if (tick) begin
`ifdef TD4_BREAKPOINT_EN
          if (bp_match) begin
            state_d = ST_HALT;
            bp_stop = 1'b1;
          end else begin
            cpu_en_d = 1'b1;
          end
`else
          cpu_en_d = 1'b1;
`endif
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_CLR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_cnt             <= '0;
      cpu_en              <= 1'b0;
      cpu_rst_n           <= 1'b0;
      load_bus.load_ready <= 1'b0;
      load_bus.prog_we    <= 1'b0;
      load_bus.prog_addr  <= '0;
      load_bus.prog_wdata <= '0;
      instr_count         <= '0;
    end else begin
      clr_cnt             <= (state_q == ST_CLR && state_d == ST_CLR) ? clr_cnt + CLR_W'(1) : '0;
      cpu_en              <= cpu_en_d;
      cpu_rst_n           <= (state_d != ST_CLR);
      load_bus.load_ready <= (state_d == ST_LOAD);
      load_bus.prog_we    <= accept;
      if (accept) begin
        load_bus.prog_addr  <= load_bus.load_addr;
        load_bus.prog_wdata <= load_bus.load_data;
      end
      // Counts the instruction retired at the edge closing each cpu_en cycle.
      if (state_d == ST_CLR) begin
        instr_count <= '0;
      end else if (cpu_en && !(&instr_count)) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

`ifdef TD4_BREAKPOINT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      if (state_d == ST_RUN && state_q != ST_RUN) begin
        first_q <= 1'b1;
      end else if (tick) begin
        first_q <= 1'b0;
      end
      if (bp_stop) begin
        bp_hit <= 1'b1;
      end else if (state_d == ST_RUN || state_d == ST_STEP || state_d == ST_CLR) begin
        bp_hit <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - randomized self-checking bench for td4_run_ctrl
module tb_td4_run_ctrl;

  localparam int STEP_DIV   = 3;
  localparam int RST_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam logic [2:0] S_CLR  = 3'd0;
  localparam logic [2:0] S_HALT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             run_req = 1'b0;
  logic             halt_req = 1'b0;
  logic             step_req = 1'b0;
  logic             restart_req = 1'b0;
  logic             cpu_en;
  logic             cpu_rst_n;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  td4_run_ctrl_if load_bus();

`ifdef TD4_BREAKPOINT_EN
  logic [3:0] cpu_ip = 4'd0;
  logic [3:0] bp_addr = 4'd0;
  logic       bp_enable = 1'b0;
  logic       bp_hit;

  always @(posedge clock) begin
    if (!cpu_rst_n) cpu_ip <= 4'd0;
    else if (cpu_en) cpu_ip <= cpu_ip + 4'd1;
  end
`endif

  int vectors = 0;
  int miscompares = 0;
  int m_count = 0;

  always #5 clock = ~clock;

  td4_run_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .RST_CYCLES(RST_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .restart_req(restart_req),
    .load_bus   (load_bus),
`ifdef TD4_BREAKPOINT_EN
    .cpu_ip     (cpu_ip),
    .bp_addr    (bp_addr),
    .bp_enable  (bp_enable),
    .bp_hit     (bp_hit),
`endif
    .cpu_en     (cpu_en),
    .cpu_rst_n  (cpu_rst_n),
    .state      (state),
    .instr_count(instr_count)
  );

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state === s) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0;
    cyc();
    cyc();
    vectors++;
    if ({state, cpu_en, cpu_rst_n, load_bus.load_ready, load_bus.prog_we, load_bus.prog_addr,
         load_bus.prog_wdata, instr_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: state=%0d en=%b rst_n=%b ready=%b we=%b addr=%h data=%h cnt=%0d required all zero",
               state, cpu_en, cpu_rst_n, load_bus.load_ready, load_bus.prog_we, load_bus.prog_addr,
               load_bus.prog_wdata, instr_count);
    end
    reset = 1'b1;
    for (int i = 0; i < RST_CYCLES; i++) begin
      vectors++;
      if (state !== S_CLR || cpu_rst_n !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_hold[%0d]: state=%0d rst_n=%b required state=0 rst_n=0", i, state, cpu_rst_n);
      end
      cyc();
    end
    vectors++;
    if (state !== S_HALT || cpu_rst_n !== 1'b1 || cpu_en !== 1'b0 || instr_count !== '0) begin
      miscompares++;
      $display("FAIL clr_exit: state=%0d rst_n=%b en=%b cnt=%0d required state=1 rst_n=1 en=0 cnt=0",
               state, cpu_rst_n, cpu_en, instr_count);
    end
    wait_state(S_HALT, 1, ok);
    m_count = 0;
  endtask

  task automatic test_load(input int n, input bit rnd);
    logic [3:0] a[16];
    logic [7:0] d[16];
    logic [7:0] fixed_d[3];
    int idx = 0, cap = 0, cyc_n = 0, last_we = -10, en_seen = 0;
    bit was_hs, b2b = 1'b1, ok;
    fixed_d = '{8'hA3, 8'h63, 8'h00};
    for (int i = 0; i < n; i++) begin
      a[i] = rnd ? 4'($urandom) : 4'(i);
      d[i] = rnd ? 8'($urandom) : fixed_d[i % 3];
    end
    load_bus.load_valid = 1'b1;
    load_bus.load_addr  = a[0];
    load_bus.load_data  = d[0];
    load_bus.load_last  = (n == 1);
    while (cap < n && cyc_n < 200) begin
      was_hs = load_bus.load_valid && load_bus.load_ready;
      if (rnd) {restart_req, step_req, run_req, halt_req} = 4'($urandom);
      cyc();
      cyc_n++;
      {restart_req, step_req, run_req, halt_req} = 4'b0;
      if (cpu_en) en_seen++;
      if (load_bus.prog_we) begin
        vectors++;
        if (cap >= n || load_bus.prog_addr !== a[cap] || load_bus.prog_wdata !== d[cap]) begin
          miscompares++;
          $display("FAIL load_write[%0d]: addr=%h data=%h required addr=%h data=%h",
                   cap, load_bus.prog_addr, load_bus.prog_wdata, a[cap % 16], d[cap % 16]);
        end
        if (cap > 0 && cyc_n != last_we + 1) b2b = 1'b0;
        last_we = cyc_n;
        if (cap == n - 1) begin
          vectors++;
          if (state !== S_CLR || cpu_rst_n !== 1'b0) begin
            miscompares++;
            $display("FAIL load_to_clr: state=%0d rst_n=%b required state=0 rst_n=0", state, cpu_rst_n);
          end
        end
        cap++;
      end
      if (was_hs) idx++;
      if (idx < n) begin
        load_bus.load_valid = rnd ? (($urandom_range(0, 3) != 0) || !load_bus.load_ready) : 1'b1;
        load_bus.load_addr  = a[idx];
        load_bus.load_data  = d[idx];
        load_bus.load_last  = (idx == n - 1);
      end else begin
        load_bus.load_valid = 1'b0;
        load_bus.load_last  = 1'b0;
      end
    end
    load_bus.load_valid = 1'b0;
    load_bus.load_last  = 1'b0;
    vectors++;
    if (cap != n) begin
      miscompares++;
      $display("FAIL load_beats: writes=%0d required %0d", cap, n);
    end
    if (!rnd) begin
      vectors++;
      if (!b2b) begin
        miscompares++;
        $display("FAIL load_back_to_back: writes not on consecutive cycles, required consecutive");
      end
    end
    vectors++;
    if (en_seen != 0) begin
      miscompares++;
      $display("FAIL load_cpu_en: pulses=%0d required 0", en_seen);
    end
    wait_state(S_HALT, 20, ok);
    m_count = 0;
    vectors++;
    if (!ok || cpu_rst_n !== 1'b1 || instr_count !== CNT_W'(m_count)) begin
      miscompares++;
      $display("FAIL load_return_halt: state=%0d rst_n=%b cnt=%0d required state=1 rst_n=1 cnt=0",
               state, cpu_rst_n, instr_count);
    end
  endtask

  task automatic test_run(input int h, input bit noise);
    int pulses = 0;
    bit exp_en;
    logic [2:0] exp_state;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int t = 0; t <= h + 4; t++) begin
      exp_en    = (t > 0) && (t <= h) && (t % STEP_DIV == 0);
      exp_state = (t <= h) ? S_RUN : S_HALT;
      if (exp_en) pulses++;
      vectors++;
      if (cpu_en !== exp_en || state !== exp_state) begin
        miscompares++;
        $display("FAIL run_h%0d_t%0d: en=%b state=%0d required en=%b state=%0d",
                 h, t, cpu_en, state, exp_en, exp_state);
      end
      if (noise && t < h) begin
        step_req            = 1'($urandom);
        run_req             = 1'($urandom);
        load_bus.load_valid = 1'($urandom);
      end
      if (t == h) halt_req = 1'b1;
      cyc();
      {step_req, run_req, halt_req} = 3'b0;
      load_bus.load_valid = 1'b0;
    end
    m_count = sat(m_count + pulses);
    vectors++;
    if (instr_count !== CNT_W'(m_count)) begin
      miscompares++;
      $display("FAIL run_count_h%0d: cnt=%0d required %0d", h, instr_count, m_count);
    end
  endtask

  task automatic test_step(input int n);
    for (int k = 0; k < n; k++) begin
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      vectors++;
      if (state !== S_STEP || cpu_en !== 1'b1) begin
        miscompares++;
        $display("FAIL step_pulse[%0d]: state=%0d en=%b required state=4 en=1", k, state, cpu_en);
      end
      cyc();
      cyc();
      m_count = sat(m_count + 1);
      vectors++;
      if (state !== S_HALT || cpu_en !== 1'b0 || instr_count !== CNT_W'(m_count)) begin
        miscompares++;
        $display("FAIL step_after[%0d]: state=%0d en=%b cnt=%0d required state=1 en=0 cnt=%0d",
                 k, state, cpu_en, instr_count, m_count);
      end
    end
  endtask

  task automatic test_priority(input int iters);
    logic [3:0] cmd;
    logic [2:0] exp_state;
    bit ok;
    for (int k = 0; k < iters; k++) begin
      cmd = (k == 0) ? 4'b1001 : 4'($urandom);
      {halt_req, restart_req, step_req, run_req} = cmd;
      if (cmd[3])      exp_state = S_HALT;
      else if (cmd[2]) exp_state = S_CLR;
      else if (cmd[1]) exp_state = S_STEP;
      else if (cmd[0]) exp_state = S_RUN;
      else             exp_state = S_HALT;
      cyc();
      {halt_req, restart_req, step_req, run_req} = 4'b0;
      vectors++;
      if (state !== exp_state) begin
        miscompares++;
        $display("FAIL priority[%0d] cmd=%b: state=%0d required %0d", k, cmd, state, exp_state);
      end
      if (exp_state == S_RUN) begin
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
      end
      if (exp_state == S_STEP) m_count = sat(m_count + 1);
      if (exp_state == S_CLR) m_count = 0;
      wait_state(S_HALT, 20, ok);
      cyc();
      vectors++;
      if (!ok || instr_count !== CNT_W'(m_count) || cpu_en !== 1'b0) begin
        miscompares++;
        $display("FAIL priority_recover[%0d]: state=%0d cnt=%0d en=%b required state=1 cnt=%0d en=0",
                 k, state, instr_count, cpu_en, m_count);
      end
    end
  endtask

  task automatic test_restart_run(input int h);
    bit ok;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int t = 0; t < h; t++) cyc();
    restart_req = 1'b1;
    cyc();
    restart_req = 1'b0;
    m_count = 0;
    vectors++;
    if (state !== S_CLR || instr_count !== '0 || cpu_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_run_h%0d: state=%0d cnt=%0d rst_n=%b required state=0 cnt=0 rst_n=0",
               h, state, instr_count, cpu_rst_n);
    end
    wait_state(S_HALT, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL restart_return: state=%0d required 1", state);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int t = 0; t < 5; t++) cyc();
    reset = 1'b0;
    #2;
    vectors++;
    if (state !== S_CLR || cpu_en !== 1'b0 || cpu_rst_n !== 1'b0 || instr_count !== '0) begin
      miscompares++;
      $display("FAIL async_reset: state=%0d en=%b rst_n=%b cnt=%0d required 0/0/0/0",
               state, cpu_en, cpu_rst_n, instr_count);
    end
    cyc();
    reset = 1'b1;
    m_count = 0;
    wait_state(S_HALT, 20, ok);
    vectors++;
    if (!ok || cpu_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_recover: state=%0d rst_n=%b required state=1 rst_n=1", state, cpu_rst_n);
    end
  endtask

`ifdef TD4_BREAKPOINT_EN
  task automatic test_breakpoint();
    int pulses = 0, t = 0;
    bit ok;
    restart_req = 1'b1;
    cyc();
    restart_req = 1'b0;
    wait_state(S_HALT, 20, ok);
    m_count   = 0;
    bp_addr   = 4'd2;
    bp_enable = 1'b1;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    while (state === S_RUN && t < 40) begin
      if (cpu_en) pulses++;
      cyc();
      t++;
    end
    vectors++;
    if (state !== S_HALT || bp_hit !== 1'b1 || cpu_ip !== 4'd2 || pulses != 2 || t != 3 * STEP_DIV) begin
      miscompares++;
      $display("FAIL bp_halt: state=%0d hit=%b ip=%0d pulses=%0d t=%0d required 1/1/2/2/%0d",
               state, bp_hit, cpu_ip, pulses, t, 3 * STEP_DIV);
    end
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    vectors++;
    if (state !== S_RUN || bp_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_resume: state=%0d hit=%b required state=3 hit=0", state, bp_hit);
    end
    for (int k = 0; k < 7; k++) cyc();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    vectors++;
    if (state !== S_HALT || cpu_ip !== 4'd4 || bp_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_past: state=%0d ip=%0d hit=%b required state=1 ip=4 hit=0", state, cpu_ip, bp_hit);
    end
    bp_enable = 1'b0;
    cyc();
    m_count = 4;
  endtask
`endif

  initial begin
    load_bus.load_valid = 1'b0;
    load_bus.load_addr  = '0;
    load_bus.load_data  = '0;
    load_bus.load_last  = 1'b0;
    test_reset();
    test_load(3, 1'b0);
    test_load(int'($urandom_range(1, 16)), 1'b1);
    test_load(int'($urandom_range(1, 16)), 1'b1);
    test_run(9, 1'b0);
    for (int i = 0; i < 4; i++) test_run(int'($urandom_range(1, 20)), 1'b1);
    test_restart_run(int'($urandom_range(4, 12)));
    test_step(3);
    test_priority(12);
    test_async_reset();
`ifdef TD4_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_run(int'($urandom_range(1, 20)), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
